qtable_arbiter: RTL
===================

QTABLE_ARBITER -- requirements
Module: qtable_arbiter

Interface
REQ-001 Parameter ADDR_W, 14, Q-table address width ({state[11:0], action[1:0]}).
REQ-002 Parameter DATA_W, 16, Q-value width.
REQ-003 clk  in  1  system clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 en  in  1  arbitration enable, driven by the control unit's QA signal.
REQ-006 req_a / req_b  in  1  access request from agent A / B.
REQ-007 we_a / we_b  in  1  1 = write, 0 = read; qualified by req.
REQ-008 addr_a / addr_b  in  ADDR_W  Q-table address.
REQ-009 wdata_a / wdata_b  in  DATA_W  write data.
REQ-010 gnt_a / gnt_b  out  1  one-cycle grant pulse; the memory access is issued in this cycle.
REQ-011 rvalid_a / rvalid_b  out  1  one-cycle read-data-valid pulse.
REQ-012 rdata_a / rdata_b  out  DATA_W  read data; valid only with rvalid.
REQ-013 mem_en, mem_we  out  1  single-port BRAM enable and write enable.
REQ-014 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  BRAM address and write data.
REQ-015 mem_rdata  in  DATA_W  BRAM read data; 1-cycle read latency.
REQ-016 busy  out  1  high whenever the state is not ARB_IDLE.
REQ-017 conflict_cnt  out  16  debug count of contended arbitrations.

Function
REQ-018 The FSM SHALL have three states: ARB_IDLE, ARB_GNT, ARB_RD.
REQ-019 ARB_IDLE: if en=1 and any req=1, select a winner and go to ARB_GNT; otherwise stay in ARB_IDLE.
REQ-020 ARB_GNT: gnt of the winner=1; mem_en=1; mem_we, mem_addr and mem_wdata come from registered copies of the winner's inputs; go to ARB_RD on a read, to ARB_IDLE on a write.
REQ-021 ARB_RD: rvalid of the winner=1 and rdata=mem_rdata; go to ARB_IDLE.
REQ-022 Latency from a req sampled in ARB_IDLE: gnt at +1 cycle, rvalid at +2 cycles; a write occupies 2 cycles and a read 3 cycles.
REQ-023 Requester rule: hold req, we, addr and wdata stable until gnt is seen; req is ignored in ARB_GNT and ARB_RD.
REQ-024 Round-robin: with a single requester, that requester wins; with both requesting, the one not granted last wins; after reset the last-granted pointer favours A.
REQ-025 conflict_cnt SHALL increment on each ARB_IDLE decision with req_a=req_b=1 and saturate at 16'hFFFF.
REQ-026 en=0 SHALL block new grants; an access already in ARB_GNT or ARB_RD completes normally, including its rvalid.
REQ-027 mem_en, gnt_* and rvalid_* SHALL be 0 in every cycle not listed in REQ-020/021; rdata_* holds its last value.

Reset
REQ-028 rst=1: state=ARB_IDLE, pointer=A, lock cleared, conflict_cnt=0, and gnt_*, rvalid_*, mem_en, mem_we=0, mem_addr=0, mem_wdata=0, rdata_*=0.
REQ-029 Reset mid-access SHALL abort it: no rvalid is issued for an in-flight read.

Configuration
REQ-030 Macro QARB_RMW_LOCK_EN defined: a read grant to agent X locks the table to X; the other agent is not granted until X is granted a write or en=0. While locked, X wins regardless of pointer, and conflict_cnt still counts contention.
REQ-031 QARB_RMW_LOCK_EN undefined: no lock state exists and plain round-robin applies.

Structure
REQ-032 Package qlearn_pkg SHALL hold Q_ADDR_W, Q_DATA_W, the arbiter state encoding typedef and the requester-ID typedef (REQ_A=0, REQ_B=1).
REQ-033 Sub-module rr_arbiter2 SHALL provide the combinational 2-way round-robin pick (inputs: req pair, last pointer, lock; output: winner ID); the pointer register stays in qtable_arbiter.

Verification
REQ-034 Single read: req_a=1, we_a=0, addr_a=14'h0123, BRAM[0x0123]=16'h00AB -> gnt_a at +1, mem_addr=0x0123, rvalid_a at +2 with rdata_a=16'h00AB.
REQ-035 Contention: req_a=req_b=1 (writes) held until granted, starting after reset -> grant order A, B, A, B; conflict_cnt=1 after the first decision.
REQ-036 Lock (QARB_RMW_LOCK_EN): A reads 0x0010, B requests continuously, A writes 0x0010 eight cycles later -> gnt_b=0 until after A's write grant, then gnt_b.
REQ-037 Enable gating: en=0 with req_b=1 for 10 cycles -> no gnt_b and busy=0; en=1 -> gnt_b on the next cycle.
REQ-038 Reset mid-read: rst=1 in ARB_GNT of a B read -> rvalid_b stays 0, busy=0 the cycle after reset, and conflict_cnt=0.
REQ-039 Saturation: force 65,536 contended decisions -> conflict_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/qlearn_pkg.sv
// Shared Q-table arbiter types: widths, FSM state encoding and requester IDs.
package qlearn_pkg;

    localparam int Q_ADDR_W = 14;
    localparam int Q_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT  = 2'd1,
        ARB_RD   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    function automatic req_id_e other_id(input req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/qtable_arbiter_rr.sv
// rr_arbiter2: combinational 2-way round-robin pick with optional lock override.
module rr_arbiter2
    import qlearn_pkg::*;
(
    input  logic    req_a_i,
    input  logic    req_b_i,
    input  req_id_e ptr_i,
    input  logic    lock_i,
    input  req_id_e lock_id_i,
    output logic    valid_o,
    output req_id_e winner_o
);

    always_comb begin
        valid_o  = 1'b0;
        winner_o = ptr_i;
        // A held lock admits only its owner, even if the other side asks.
        if (lock_i) begin
            valid_o  = (lock_id_i == REQ_A) ? req_a_i : req_b_i;
            winner_o = lock_id_i;
        end else if (req_a_i && req_b_i) begin
            valid_o  = 1'b1;
            winner_o = ptr_i;
        end else if (req_a_i) begin
            valid_o  = 1'b1;
            winner_o = REQ_A;
        end else if (req_b_i) begin
            valid_o  = 1'b1;
            winner_o = REQ_B;
        end
    end

endmodule

// File: rtl/qtable_arbiter.sv
// Two-agent arbiter for a single-port Q-table BRAM (1-cycle read latency).
// Optional read-modify-write lock: define QARB_RMW_LOCK_EN.
module qtable_arbiter
    import qlearn_pkg::*;
#(
    parameter int ADDR_W = Q_ADDR_W,
    parameter int DATA_W = Q_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [15:0]       conflict_cnt
);

    arb_state_e        state_q;
    req_id_e           ptr_q;
    req_id_e           win_q;
    logic              gnt_a_q, gnt_b_q;
    logic              rvalid_a_q, rvalid_b_q;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic [15:0]       cnt_q;

    logic              pick_vld;
    req_id_e           pick_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              decide;
    logic              lock_vld;
    req_id_e           lock_id;

`ifdef QARB_RMW_LOCK_EN
    logic    lock_q;
    req_id_e lock_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= REQ_A;
        end else if (!en) begin
            lock_q    <= 1'b0;
        end else if (decide) begin
            lock_q    <= !sel_we;
            lock_id_q <= pick_id;
        end
    end

    assign lock_vld = lock_q;
    assign lock_id  = lock_id_q;
`else
    assign lock_vld = 1'b0;
    assign lock_id  = REQ_A;
`endif

    rr_arbiter2 u_rr (
        .req_a_i   (req_a),
        .req_b_i   (req_b),
        .ptr_i     (ptr_q),
        .lock_i    (lock_vld),
        .lock_id_i (lock_id),
        .valid_o   (pick_vld),
        .winner_o  (pick_id)
    );

    assign decide    = (state_q == ARB_IDLE) && en && pick_vld;
    assign sel_we    = (pick_id == REQ_A) ? we_a    : we_b;
    assign sel_addr  = (pick_id == REQ_A) ? addr_a  : addr_b;
    assign sel_wdata = (pick_id == REQ_A) ? wdata_a : wdata_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= REQ_A;
            win_q       <= REQ_A;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            cnt_q       <= '0;
        end else begin
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            mem_en_q   <= 1'b0;
            if (rvalid_a_q) rdata_a_q <= mem_rdata;
            if (rvalid_b_q) rdata_b_q <= mem_rdata;
            unique case (state_q)
                ARB_IDLE: begin
                    if (decide) begin
                        state_q     <= ARB_GNT;
                        win_q       <= pick_id;
                        ptr_q       <= other_id(pick_id);
                        gnt_a_q     <= (pick_id == REQ_A);
                        gnt_b_q     <= (pick_id == REQ_B);
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        if (req_a && req_b && cnt_q != 16'hFFFF)
                            cnt_q <= cnt_q + 16'd1;
                    end
                end
                ARB_GNT: begin
                    if (mem_we_q) begin
                        state_q <= ARB_IDLE;
                    end else begin
                        state_q    <= ARB_RD;
                        rvalid_a_q <= (win_q == REQ_A);
                        rvalid_b_q <= (win_q == REQ_B);
                    end
                end
                ARB_RD:  state_q <= ARB_IDLE;
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Read data is forwarded straight from the BRAM in the rvalid cycle.
    assign rdata_a      = rvalid_a_q ? mem_rdata : rdata_a_q;
    assign rdata_b      = rvalid_b_q ? mem_rdata : rdata_b_q;
    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign rvalid_a     = rvalid_a_q;
    assign rvalid_b     = rvalid_b_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q != ARB_IDLE);
    assign conflict_cnt = cnt_q;

endmodule
